lcis_ram_scanner: RTL and testbench



---
 rtl/lcis_pkg.sv | 14 +
 rtl/lcis_run_tracker.sv | 52 +++++
 rtl/lcis_ram_scanner.sv | 137 +++++++++++++
 tb/tb_lcis_ram_scanner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcis_pkg.sv
// Shared definitions for the LCIS RAM scanner: FSM state encoding and its width.
package lcis_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/lcis_run_tracker.sv
// Longest strictly increasing contiguous run tracker. Consumes one element per
// valid cycle; best reflects the element presented this cycle when valid is high.
module lcis_run_tracker #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   valid,
  input  logic                   first,
  input  logic [DATA_WIDTH-1:0]  x,
  output logic [COUNT_WIDTH-1:0] best
);

  logic [DATA_WIDTH-1:0]  prev;
  logic [COUNT_WIDTH-1:0] cur_q;
  logic [COUNT_WIDTH-1:0] best_q;
  logic [COUNT_WIDTH-1:0] cur_n;
  logic [COUNT_WIDTH-1:0] best_n;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cur_n  = cur_q;
    best_n = best_q;
    if (valid) begin
      if (first || !(x > prev)) cur_n = COUNT_WIDTH'(1);
      else                      cur_n = cur_q + 1'b1;
      best_n = (cur_n > best_q) ? cur_n : best_q;
    end
  end

  assign best = best_n;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      cur_q  <= '0;
      best_q <= '0;
    end else if (clear) begin
      prev   <= '0;
      cur_q  <= '0;
      best_q <= '0;
    end else if (valid) begin
      prev   <= x;
      cur_q  <= cur_n;
      best_q <= best_n;
    end
  end

endmodule

// File: rtl/lcis_ram_scanner.sv
// Streams N words from a 1-cycle-latency RAM and reports the longest strictly
// increasing run. Define LCIS_WRITEBACK_EN to also write the result back to RAM.
module lcis_ram_scanner
  import lcis_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num,
  input  logic [ADDR_WIDTH-1:0] result_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_write_req,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_e                state;
  logic [ADDR_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  rd_valid;
  logic                  rd_first;
  logic [ADDR_WIDTH-1:0] best;
  logic                  accept;

`ifdef LCIS_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] result_addr_q;
`else
  logic unused_result_addr;
  assign unused_result_addr = ^result_addr;
  assign ram_din            = '0;
  assign ram_write_req      = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && start;

  lcis_run_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .COUNT_WIDTH(ADDR_WIDTH)
  ) u_tracker (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .valid(rd_valid),
    .first(rd_first),
    .x    (ram_dout),
    .best (best)
  );

  // N=0 passes through DRAIN with an empty pipeline so done keeps the N+1 latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      num_q         <= '0;
      idx           <= '0;
      rd_valid      <= 1'b0;
      rd_first      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      ram_addr      <= '0;
`ifdef LCIS_WRITEBACK_EN
      result_addr_q <= '0;
      ram_din       <= '0;
      ram_write_req <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q  <= num;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
`ifdef LCIS_WRITEBACK_EN
            result_addr_q <= result_addr;
`endif
            if (num == '0) begin
              state <= ST_DRAIN;
            end else begin
              state    <= ST_READ;
              ram_addr <= base_addr;
            end
          end
        end
        ST_READ: begin
          // Valid/first travel one cycle behind the address to meet the RAM data.
          rd_valid <= 1'b1;
          rd_first <= (idx == '0);
          if (idx == num_q - 1'b1) begin
            state    <= ST_DRAIN;
            ram_addr <= '0;
          end else begin
            idx      <= idx + 1'b1;
            ram_addr <= ram_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
`ifdef LCIS_WRITEBACK_EN
          state         <= ST_WB;
          ram_addr      <= result_addr_q;
          ram_din       <= DATA_WIDTH'(best);
          ram_write_req <= 1'b1;
`else
          state  <= ST_DONE;
          result <= best;
          done   <= 1'b1;
          busy   <= 1'b0;
`endif
        end
`ifdef LCIS_WRITEBACK_EN
        ST_WB: begin
          state         <= ST_DONE;
          ram_addr      <= '0;
          ram_din       <= '0;
          ram_write_req <= 1'b0;
          result        <= best;
          done          <= 1'b1;
          busy          <= 1'b0;
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcis_ram_scanner.sv
// Self-checking bench for lcis_ram_scanner with a behavioural RAM and a
// queue-based reference model; honours LCIS_WRITEBACK_EN when defined.
module tb_lcis_ram_scanner;

  localparam int DW = 16;
  localparam int AW = 16;
`ifdef LCIS_WRITEBACK_EN
  localparam int WB_EXTRA = 1;
`else
  localparam int WB_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num = '0;
  logic [AW-1:0] result_addr = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] result;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_write_req;
  logic [DW-1:0] ram_dout;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lcis_ram_scanner #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num          (num),
    .result_addr  (result_addr),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_write_req(ram_write_req),
    .ram_dout     (ram_dout)
  );

  // Single-port RAM with registered read; a bench-only preload port shares the write path.
  always @(posedge clk) begin
    if (pre_we)             mem[pre_addr] <= pre_data;
    else if (ram_write_req) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lcis_model(input logic [DW-1:0] v[$]);
    int cur = 0;
    int best = 0;
    for (int i = 0; i < v.size(); i++) begin
      if (i > 0 && v[i] > v[i-1]) cur = cur + 1;
      else                        cur = 1;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  task automatic load(input logic [AW-1:0] base, input logic [DW-1:0] v[$]);
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = base + AW'(i);
      pre_data = v[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_scan(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] raddr,
                          input logic [DW-1:0] v[$], input int poke);
    int n;
    int exp_res;
    int exp_lat;
    int lat;
    int bad_addr;
    int bad_busy;
    int wr_cnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_din;
    n        = v.size();
    exp_res  = lcis_model(v);
    exp_lat  = n + 1 + WB_EXTRA;
    lat      = -1;
    bad_addr = 0;
    bad_busy = 0;
    wr_cnt   = 0;
    wr_addr  = '0;
    wr_din   = '0;
    load(base, v);
    @(negedge clk);
    base_addr   = base;
    num         = AW'(n);
    result_addr = raddr;
    start       = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k <= exp_lat + 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 0) start = 1'b0;
      if (poke > 0 && k == poke) begin
        start     = 1'b1;
        base_addr = 16'h1234;
        num       = 16'd2;
      end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (k < n) begin
        if (ram_addr !== base + AW'(k)) bad_addr++;
      end else if (!ram_write_req && ram_addr !== '0) begin
        bad_addr++;
      end
      if (ram_write_req) begin
        wr_cnt++;
        wr_addr = ram_addr;
        wr_din  = ram_din;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) bad_busy++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_addr_seq"}, bad_addr, 0);
    check({tag, "_busy_during"}, bad_busy, 0);
`ifdef LCIS_WRITEBACK_EN
    check({tag, "_wr_count"}, wr_cnt, 1);
    check({tag, "_wr_addr"}, wr_addr, raddr);
    check({tag, "_wr_din"}, wr_din, exp_res);
    check({tag, "_wr_readback"}, mem[raddr], exp_res);
`else
    check({tag, "_wr_count"}, wr_cnt, 0);
`endif
    // A start arriving in the DONE cycle must be dropped.
    start     = 1'b1;
    base_addr = 16'h0000;
    num       = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_start_in_done"}, busy, 0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [AW-1:0] rb;

    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_din", ram_din, 0);
    check("reset_wr", ram_write_req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    q = {16'd1, 16'd3, 16'd5, 16'd4, 16'd7};
    run_scan("case1", 16'h0010, 16'h0100, q, 0);
    q = {16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
    run_scan("equal", 16'h0200, 16'h0100, q, 0);
    q = {16'd9, 16'd8, 16'd7};
    run_scan("desc", 16'h0300, 16'h0100, q, 0);
    q = {16'd0, 16'd1, 16'd2, 16'd3};
    run_scan("asc", 16'h0400, 16'h0100, q, 0);
    q = {};
    run_scan("n0", 16'h0500, 16'h0100, q, 0);
    q = {16'd1, 16'd2, 16'd3, 16'd0};
    run_scan("wrap", 16'hFFFE, 16'h0100, q, 0);

    // Reset in the middle of a scan.
    q = {16'd1, 16'd3, 16'd5, 16'd4, 16'd7};
    load(16'h0010, q);
    @(negedge clk);
    base_addr = 16'h0010;
    num       = 16'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midrst_result_cleared", result, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_addr_elem2", ram_addr, 16'h0012);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_wr", ram_write_req, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("after_rst_poke", 16'h0010, 16'h0100, q, 2);

    // Randomised arrays with small value range so runs and ties occur.
    for (int t = 0; t < 8; t++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) q.push_back(DW'($urandom_range(0, 5)));
      rb = 16'hF000 + AW'($urandom_range(0, 16'h0FFF));
      run_scan($sformatf("rand%0d", t), rb, 16'h0100, q, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
